// File: rtl/ucore_dispatch.sv
// ucore_dispatch: micro-op dispatch front end.
// CHANNELS reservation stations, each holding one decoded group of 1-3 uops
// plus a 16-bit temp. One uop issues per cycle, scheduled round-robin, with the
// last granted channel locked while the executing stage has a memory op out.
// Optional feature macro: DISPATCH_FWD_EN (forward a same-edge memory write
// into ex_t16 for the granted station).
module ucore_dispatch #(
   parameter int CHANNELS = 2,
   parameter int UOP_W    = 20,
   parameter int TAG_W    = 2
) (
   input  logic             clk,
   input  logic             a_rst,
   input  logic             hold,
   input  logic [UOP_W-1:0] id_uop_0,
   input  logic [UOP_W-1:0] id_uop_1,
   input  logic [UOP_W-1:0] id_uop_2,
   input  logic [1:0]       id_uop_cnt,
   input  logic [15:0]      id_k16,
   output logic             id_feed_req,
   input  logic [15:0]      mem_data_in,
   input  logic             mem_data_wr,
   input  logic [TAG_W-1:0] mem_data_tag,
   input  logic             ex_ready,
   input  logic             ex_mem_busy,
   output logic             ex_valid,
   output logic [UOP_W-1:0] ex_uop,
   output logic [TAG_W-1:0] ex_tag,
   output logic [15:0]      ex_t16,
   output logic             ex_last
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_LOADED = 1'b1} st_e;

   // Per-station storage
   st_e              state_q [CHANNELS];
   st_e              state_d [CHANNELS];
   logic [UOP_W-1:0] slot_q  [CHANNELS][3];
   logic [UOP_W-1:0] slot_d  [CHANNELS][3];
   logic [1:0]       rd_q    [CHANNELS];
   logic [1:0]       rd_d    [CHANNELS];
   logic [1:0]       cnt_q   [CHANNELS];
   logic [1:0]       cnt_d   [CHANNELS];
   logic [15:0]      temp_q  [CHANNELS];
   logic [15:0]      temp_d  [CHANNELS];

   // Scheduler state
   logic [TAG_W-1:0] rr_last_q, rr_last_d;
   logic [TAG_W-1:0] lock_q, lock_d;
   logic             lock_v_q, lock_v_d;

   // Issue-stage output registers
   logic             ex_valid_q, ex_valid_d;
   logic [UOP_W-1:0] ex_uop_q, ex_uop_d;
   logic [TAG_W-1:0] ex_tag_q, ex_tag_d;
   logic [15:0]      ex_t16_q, ex_t16_d;
   logic             ex_last_q, ex_last_d;

   // Decode helpers
   logic [CHANNELS-1:0] empty_vec;
   logic [CHANNELS-1:0] loaded_vec;
   logic                load_any;
   logic [TAG_W-1:0]    load_sel;
   logic                grant_v;
   logic [TAG_W-1:0]    grant_idx;
   logic                issue_fire;
   logic                fwd_hit;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_status
         assign empty_vec[gi]  = (state_q[gi] == ST_EMPTY);
         assign loaded_vec[gi] = (state_q[gi] == ST_LOADED);
      end
   endgenerate

   assign id_feed_req = |empty_vec;

   // Pick the lowest-index empty station for an incoming group
   always_comb begin : load_pick
      load_any = 1'b0;
      load_sel = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (empty_vec[c]) begin
            load_any = 1'b1;
            load_sel = TAG_W'(c);
         end
      end
   end

   // Choose the issuing station: locked channel while memory is busy,
   // otherwise the first loaded station after rr_last (descending scan so the
   // nearest one wins).
   always_comb begin : grant_pick
      int idx;
      idx       = 0;
      grant_v   = 1'b0;
      grant_idx = '0;
      if (ex_mem_busy) begin
         if (lock_v_q && loaded_vec[lock_q]) begin
            grant_v   = 1'b1;
            grant_idx = lock_q;
         end
      end else begin
         for (int i = CHANNELS; i >= 1; i--) begin
            idx = (int'(rr_last_q) + i) % CHANNELS;
            if (loaded_vec[idx]) begin
               grant_v   = 1'b1;
               grant_idx = TAG_W'(idx);
            end
         end
      end
   end

   assign issue_fire = !hold && ex_ready && grant_v;

`ifdef DISPATCH_FWD_EN
   // A write landing on the granted station on the issue edge is forwarded.
   assign fwd_hit = mem_data_wr && (mem_data_tag == grant_idx);
`else
   assign fwd_hit = 1'b0;
`endif

   // Next-state: issue, memory write-back into temps, and group loads
   always_comb begin : next_state
      state_d    = state_q;
      slot_d     = slot_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      temp_d     = temp_q;
      rr_last_d  = rr_last_q;
      lock_d     = lock_q;
      lock_v_d   = lock_v_q;
      ex_valid_d = ex_valid_q;
      ex_uop_d   = ex_uop_q;
      ex_tag_d   = ex_tag_q;
      ex_t16_d   = ex_t16_q;
      ex_last_d  = ex_last_q;

      // Issue; hold freezes every ex_* including ex_valid
      if (!hold) begin
         if (issue_fire) begin
            ex_valid_d = 1'b1;
            ex_uop_d   = slot_q[grant_idx][rd_q[grant_idx]];
            ex_tag_d   = grant_idx;
            ex_t16_d   = fwd_hit ? mem_data_in : temp_q[grant_idx];
            ex_last_d  = (rd_q[grant_idx] == (cnt_q[grant_idx] - 2'd1));
            rd_d[grant_idx] = rd_q[grant_idx] + 2'd1;
            if (rd_q[grant_idx] == (cnt_q[grant_idx] - 2'd1)) begin
               state_d[grant_idx] = ST_EMPTY;
            end
            rr_last_d = grant_idx;
            lock_d    = grant_idx;
            lock_v_d  = 1'b1;
         end else begin
            ex_valid_d = 1'b0;
         end
      end

      // Load data only lands in stations that hold a group; out-of-range
      // tags never match any channel.
      for (int c = 0; c < CHANNELS; c++) begin
         if (mem_data_wr && (mem_data_tag == TAG_W'(c)) && loaded_vec[c]) begin
            temp_d[c] = mem_data_in;
         end
      end

      // Load targets an empty station, so it never collides with issue or
      // write-back above. A group offered with no room is dropped.
      if ((id_uop_cnt != 2'd0) && load_any) begin
         state_d[load_sel]    = ST_LOADED;
         slot_d[load_sel][0]  = id_uop_0;
         slot_d[load_sel][1]  = id_uop_1;
         slot_d[load_sel][2]  = id_uop_2;
         cnt_d[load_sel]      = id_uop_cnt;
         rd_d[load_sel]       = 2'd0;
         temp_d[load_sel]     = id_k16;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge a_rst) begin : state_reg
      if (a_rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= ST_EMPTY;
            rd_q[c]    <= 2'd0;
            cnt_q[c]   <= 2'd0;
            temp_q[c]  <= 16'h0;
            for (int s = 0; s < 3; s++) begin
               slot_q[c][s] <= '0;
            end
         end
         rr_last_q  <= TAG_W'(CHANNELS - 1);
         lock_q     <= '0;
         lock_v_q   <= 1'b0;
         ex_valid_q <= 1'b0;
         ex_uop_q   <= '0;
         ex_tag_q   <= '0;
         ex_t16_q   <= 16'h0;
         ex_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         temp_q     <= temp_d;
         rr_last_q  <= rr_last_d;
         lock_q     <= lock_d;
         lock_v_q   <= lock_v_d;
         ex_valid_q <= ex_valid_d;
         ex_uop_q   <= ex_uop_d;
         ex_tag_q   <= ex_tag_d;
         ex_t16_q   <= ex_t16_d;
         ex_last_q  <= ex_last_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_uop   = ex_uop_q;
   assign ex_tag   = ex_tag_q;
   assign ex_t16   = ex_t16_q;
   assign ex_last  = ex_last_q;

endmodule
